// File: rtl/framebuffer_pixel_writer_pkg.sv
// Shared types and helpers for the framebuffer pixel writer:
// Q16.16 fixed-point scalar and RGBA vector types, the far-plane depth value,
// the writer FSM state encoding and the RGBA8888 packing helper.
package framebuffer_pixel_writer_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] FixedPoint_t;

    typedef struct packed {
        FixedPoint_t x;   // red
        FixedPoint_t y;   // green
        FixedPoint_t z;   // blue
        FixedPoint_t w;   // alpha
    } Vector4_t;

    // Depth value written by a clear: the largest positive depth, so any
    // finite sample depth is nearer.
    localparam logic [31:0] DEPTH_FAR = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    function automatic FixedPoint_t fixed_point_multiply(input FixedPoint_t a,
                                                         input FixedPoint_t b);
        logic signed [63:0] a_ext;
        logic signed [63:0] b_ext;
        logic signed [63:0] prod;
        a_ext = {{32{a[31]}}, a};
        b_ext = {{32{b[31]}}, b};
        prod  = a_ext * b_ext;
        return prod[47:16];
    endfunction

    function automatic FixedPoint_t uint8_to_fixed_point(input logic [7:0] u);
        return {8'd0, u, 16'd0};
    endfunction

    function automatic logic [31:0] pack_rgba8888(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b,
                                                  input logic [7:0] a);
        return {r, g, b, a};
    endfunction

endpackage

// File: rtl/framebuffer_pixel_writer_conv.sv
// fixed_to_rgba8888: combinational conversion of a fixed-point RGBA vector
// (1.0 = full intensity) into packed RGBA8888. Each channel is scaled by 255,
// truncated to its integer part and clamped to 0..255.
import framebuffer_pixel_writer_pkg::*;

module fixed_to_rgba8888 (
    input  Vector4_t    colour,
    output logic [31:0] rgba
);

    function automatic logic [7:0] to_channel(input FixedPoint_t c);
        FixedPoint_t scaled;
        FixedPoint_t whole;
        scaled = fixed_point_multiply(c, uint8_to_fixed_point(8'd255));
        whole  = scaled >>> FRAC_BITS;
        if (whole < 0) begin
            return 8'd0;
        end else if (whole > 255) begin
            return 8'd255;
        end
        return whole[7:0];
    endfunction

    // Convert and pack all four channels.
    always_comb begin
        rgba = pack_rgba8888(to_channel(colour.x), to_channel(colour.y),
                             to_channel(colour.z), to_channel(colour.w));
    end

endmodule

// File: rtl/framebuffer_pixel_writer.sv
// framebuffer_pixel_writer: accepts shaded pixel samples from the rasterizer,
// optionally depth-tests them against an external depth buffer and writes
// passing pixels to the colour framebuffer as RGBA8888. Also runs a
// full-screen clear sweep of colour and depth.
//
// Build option: define FRAMEBUFFER_DEPTH_TEST_EN to enable the depth test
// (READ/COMPARE states and depth memory traffic). Without it, covered
// in-range pixels are written directly and the depth strobes stay low.
import framebuffer_pixel_writer_pkg::*;

module framebuffer_pixel_writer #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic signed [31:0] i_x,
    input  logic signed [31:0] i_y,
    input  Vector4_t          i_colour,
    input  FixedPoint_t       i_z,
    input  logic              i_write,
    input  logic              i_clear,
    input  logic [31:0]       i_clear_colour,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_depth_addr,
    output logic              o_depth_rd,
    input  logic [31:0]       i_depth_rdata,
    output logic              o_depth_wr,
    output logic [31:0]       o_depth_wdata,
    output logic [ADDR_W-1:0] o_colour_addr,
    output logic              o_colour_wr,
    output logic [31:0]       o_colour_wdata,
    output logic [31:0]       o_written_count
);

`ifdef FRAMEBUFFER_DEPTH_TEST_EN
    localparam logic DEPTH_EN = 1'b1;
`else
    localparam logic DEPTH_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t             state;
    logic               in_range;
    logic signed [31:0] lin_addr;
    logic [31:0]        conv_rgba;
    logic               take_pixel;

    fixed_to_rgba8888 u_conv (
        .colour (i_colour),
        .rgba   (conv_rgba)
    );

    assign o_ready    = (state == ST_IDLE) && !i_clear;
    assign in_range   = (i_x >= 0) && (i_x < WIDTH) && (i_y >= 0) && (i_y < HEIGHT);
    assign lin_addr   = i_y * WIDTH + i_x;
    assign take_pixel = o_ready && i_valid && i_write && in_range;

`ifdef FRAMEBUFFER_DEPTH_TEST_EN
    logic [ADDR_W-1:0] pix_addr;
    logic [31:0]       pix_rgba;
    FixedPoint_t       pix_z;

    // Hold the accepted pixel while its depth is fetched and compared.
    always_ff @(posedge i_clk) begin
        if (take_pixel) begin
            pix_addr <= ADDR_W'(lin_addr);
            pix_rgba <= conv_rgba;
            pix_z    <= i_z;
        end
    end
`else
    logic [31:0] unused_rdata;
    assign unused_rdata = i_depth_rdata;
`endif

    // Writer FSM: pixel path, clear sweep and all registered memory outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            o_depth_rd      <= 1'b0;
            o_depth_wr      <= 1'b0;
            o_colour_wr     <= 1'b0;
            o_clear_done    <= 1'b0;
            o_depth_addr    <= '0;
            o_colour_addr   <= '0;
            o_depth_wdata   <= '0;
            o_colour_wdata  <= '0;
            o_written_count <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            o_depth_rd   <= 1'b0;
            o_depth_wr   <= 1'b0;
            o_colour_wr  <= 1'b0;
            o_clear_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_clear) begin
                        // Clear wins over a simultaneous pixel; first write
                        // goes out in the next cycle at address 0.
                        state          <= ST_CLEAR;
                        o_colour_wr    <= 1'b1;
                        o_colour_addr  <= '0;
                        o_colour_wdata <= i_clear_colour;
                        o_depth_wr     <= DEPTH_EN;
                        o_depth_addr   <= '0;
                        o_depth_wdata  <= DEPTH_FAR;
                    end else if (take_pixel) begin
`ifdef FRAMEBUFFER_DEPTH_TEST_EN
                        state        <= ST_READ;
                        o_depth_rd   <= 1'b1;
                        o_depth_addr <= ADDR_W'(lin_addr);
`else
                        // No depth test: write the colour straight away.
                        state           <= ST_WRITE;
                        o_colour_wr     <= 1'b1;
                        o_colour_addr   <= ADDR_W'(lin_addr);
                        o_colour_wdata  <= conv_rgba;
                        o_depth_addr    <= ADDR_W'(lin_addr);
                        o_depth_wdata   <= i_z;
                        o_written_count <= o_written_count + 32'd1;
`endif
                    end
                end

`ifdef FRAMEBUFFER_DEPTH_TEST_EN
                ST_READ: begin
                    // Read strobe is on the bus this cycle; data arrives next.
                    state <= ST_COMPARE;
                end

                ST_COMPARE: begin
                    // Strictly nearer wins; equal depth is rejected.
                    if (pix_z < $signed(i_depth_rdata)) begin
                        state           <= ST_WRITE;
                        o_colour_wr     <= 1'b1;
                        o_colour_addr   <= pix_addr;
                        o_colour_wdata  <= pix_rgba;
                        o_depth_wr      <= 1'b1;
                        o_depth_addr    <= pix_addr;
                        o_depth_wdata   <= pix_z;
                        o_written_count <= o_written_count + 32'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
`endif

                ST_WRITE: begin
                    state <= ST_IDLE;
                end

                ST_CLEAR: begin
                    if (o_clear_done) begin
                        state <= ST_IDLE;
                    end else if (o_colour_addr != LAST_ADDR) begin
                        o_colour_wr   <= 1'b1;
                        o_colour_addr <= o_colour_addr + ADDR_W'(1);
                        o_depth_wr    <= DEPTH_EN;
                        o_depth_addr  <= o_depth_addr + ADDR_W'(1);
                    end else begin
                        // Last write was on the bus this cycle.
                        o_clear_done <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
